// File: rtl/spi_master_csr_pkg.sv
// Shared register map, bit indices and helpers for the SPI master register file.
// Revision: 1.0
`default_nettype none

package spi_master_csr_pkg;

  typedef enum logic [5:0] {
    SPI_CONFIG = 6'h00,
    SPI_STATUS = 6'h04,
    SPI_CLKDIV = 6'h08,
    SPI_CMD    = 6'h0C,
    SPI_SSEL   = 6'h10,
    SPI_TX     = 6'h18,
    SPI_RX0    = 6'h20,
    SPI_RX1    = 6'h24
  } spi_reg_e;

  localparam int SPI_ST_RXNE  = 0;
  localparam int SPI_ST_BUSY  = 1;
  localparam int SPI_ST_PFULL = 2;
  localparam int SPI_ST_OVF   = 3;

  localparam int SPI_CFG_DIS   = 0;
  localparam int SPI_CFG_IRQEN = 1;
  localparam int SPI_CFG_CPOL  = 2;
  localparam int SPI_CFG_CPHA  = 3;
  localparam int SPI_CFG_LSB   = 4;

  localparam logic [31:0] SPI_UNMAPPED = 32'hDEADBEEF;

  // Out-of-range selects saturate to the last slave rather than deselecting all.
  function automatic logic [7:0] ssel_onehot(input logic [7:0] sel, input int unsigned nss);
    logic [7:0] idx;
    if ({24'd0, sel} >= nss) idx = 8'(nss - 1);
    else                     idx = sel;
    return 8'd1 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_rxq.sv
// Synchronous RX word queue with wrap-bit pointers; a pop frees space for a same-cycle push.
// Revision: 1.0
`default_nettype none

module spi_master_rxq #(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  localparam int PTRW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_pop;
  logic            do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTRW-1] != rd_ptr[PTRW-1]) &&
                   (wr_ptr[PTRW-2:0] == rd_ptr[PTRW-2:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[PTRW-2:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTRW-2:0]] <= din;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_csr.sv
// SPI master register file: emesh decode, config/clkdiv/ssel state, RX queue and read responses.
// Build option: SPI_MASTER_IRQ_EN enables the level interrupt. Revision: 1.0
`default_nettype none

module spi_master_csr
  import spi_master_csr_pkg::*;
#(
  parameter int CLKDIV  = 1,
  parameter int AW      = 32,
  parameter int PW      = 104,
  parameter int NSS     = 4,
  parameter int RXDEPTH = 4
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           hw_en,
  input  logic [63:0]    rx_data,
  input  logic           rx_access,
  input  logic [1:0]     spi_state,
  input  logic           fifo_prog_full,
  input  logic           fifo_wait,
  output logic           cpol,
  output logic           cpha,
  output logic           lsbfirst,
  output logic           spi_en,
  output logic [7:0]     clkdiv_reg,
  output logic [NSS-1:0] ss_sel,
  output logic           irq,
  input  logic           access_in,
  input  logic [PW-1:0]  packet_in,
  output logic           wait_out,
  output logic           access_out,
  output logic [PW-1:0]  packet_out,
  input  logic           wait_in
);

`ifdef SPI_MASTER_IRQ_EN
  localparam logic [7:0] CFG_MASK = 8'hFF;
`else
  localparam logic [7:0] CFG_MASK = 8'hFD;
`endif

  // emesh layout: {srcaddr, data, dstaddr, ctrlmode[4:0], datamode[1:0], write}
  logic          req_write;
  logic [1:0]    req_datamode;
  logic [4:0]    req_ctrlmode;
  logic [AW-1:0] req_dstaddr;
  logic [31:0]   req_data;
  logic [AW-1:0] req_srcaddr;

  assign req_write    = packet_in[0];
  assign req_datamode = packet_in[2:1];
  assign req_ctrlmode = packet_in[7:3];
  assign req_dstaddr  = packet_in[8 +: AW];
  assign req_data     = packet_in[8+AW +: 32];
  assign req_srcaddr  = packet_in[40+AW +: AW];

  logic       accept;
  logic       wr_en;
  logic       rd_en;
  logic [5:0] addr;

  assign wait_out = fifo_wait | (access_out & wait_in);
  assign accept   = access_in & ~wait_out;
  assign wr_en    = accept & req_write;
  assign rd_en    = accept & ~req_write;
  assign addr     = req_dstaddr[5:0];

  logic [7:0]  config_reg;
  logic [7:0]  ssel_reg;
  logic        rx_ovf;
  logic [7:0]  status;
  logic [63:0] rxq_head;
  logic        rxq_full;
  logic        rxq_empty;
  logic        rxq_pop;
  logic [31:0] rdata;

  spi_master_rxq #(
    .DW    (64),
    .DEPTH (RXDEPTH)
  ) u_rxq (
    .clk    (clk),
    .nreset (nreset),
    .push   (rx_access),
    .din    (rx_data),
    .pop    (rxq_pop),
    .dout   (rxq_head),
    .full   (rxq_full),
    .empty  (rxq_empty)
  );

  assign rxq_pop = rd_en & (addr == SPI_RX1) & ~rxq_empty;
  assign status  = {4'b0000, rx_ovf, fifo_prog_full, |spi_state, ~rxq_empty};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      config_reg <= 8'h00;
      clkdiv_reg <= 8'(CLKDIV);
      ssel_reg   <= 8'h00;
    end else if (wr_en) begin
      case (addr)
        SPI_CONFIG: config_reg <= req_data[7:0] & CFG_MASK;
        SPI_CLKDIV: clkdiv_reg <= req_data[7:0];
        SPI_SSEL:   ssel_reg   <= req_data[7:0];
        default: ;
      endcase
    end
  end

  // A dropped push in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      rx_ovf <= 1'b0;
    else if (rx_access & rxq_full & ~rxq_pop)
      rx_ovf <= 1'b1;
    else if (wr_en && (addr == SPI_STATUS) && req_data[SPI_ST_OVF])
      rx_ovf <= 1'b0;
  end

  always_comb begin
    rdata = SPI_UNMAPPED;
    case (addr)
      SPI_CONFIG: rdata = {24'd0, config_reg};
      SPI_STATUS: rdata = {24'd0, status};
      SPI_CLKDIV: rdata = {24'd0, clkdiv_reg};
      SPI_SSEL:   rdata = {24'd0, ssel_reg};
      SPI_RX0:    rdata = rxq_empty ? 32'd0 : rxq_head[31:0];
      SPI_RX1:    rdata = rxq_empty ? 32'd0 : rxq_head[63:32];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      access_out <= 1'b0;
      packet_out <= '0;
    end else if (!(access_out & wait_in)) begin
      access_out <= rd_en;
      if (rd_en)
        packet_out <= {{AW{1'b0}}, rdata, req_srcaddr, req_ctrlmode, req_datamode, 1'b1};
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) irq <= 1'b0;
    else         irq <= config_reg[SPI_CFG_IRQEN] & (status[SPI_ST_RXNE] | status[SPI_ST_OVF]);
  end
`else
  assign irq = 1'b0;
`endif

  assign cpol     = config_reg[SPI_CFG_CPOL];
  assign cpha     = config_reg[SPI_CFG_CPHA];
  assign lsbfirst = config_reg[SPI_CFG_LSB];
  assign spi_en   = hw_en & ~config_reg[SPI_CFG_DIS];
  assign ss_sel   = NSS'(ssel_onehot(ssel_reg, NSS));

  logic unused_req;
  assign unused_req = ^{req_dstaddr[AW-1:6], req_data[31:8]};

endmodule

`default_nettype wire

// File: tb/tb_spi_master_csr.sv
// Directed self-checking bench for spi_master_csr (default parameters).
// Revision: 1.0
`default_nettype none

module tb_spi_master_csr;
  import spi_master_csr_pkg::*;

  localparam int PW = 104;

  logic          clk = 1'b0;
  logic          nreset;
  logic          hw_en;
  logic [63:0]   rx_data;
  logic          rx_access;
  logic [1:0]    spi_state;
  logic          fifo_prog_full;
  logic          fifo_wait;
  logic          cpol, cpha, lsbfirst, spi_en, irq;
  logic [7:0]    clkdiv_reg;
  logic [3:0]    ss_sel;
  logic          access_in;
  logic [PW-1:0] packet_in;
  logic          wait_out;
  logic          access_out;
  logic [PW-1:0] packet_out;
  logic          wait_in;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd;
  logic        irq_exp;

  spi_master_csr #(
    .CLKDIV (1), .AW (32), .PW (PW), .NSS (4), .RXDEPTH (4)
  ) dut (
    .clk (clk), .nreset (nreset), .hw_en (hw_en), .rx_data (rx_data),
    .rx_access (rx_access), .spi_state (spi_state), .fifo_prog_full (fifo_prog_full),
    .fifo_wait (fifo_wait), .cpol (cpol), .cpha (cpha), .lsbfirst (lsbfirst),
    .spi_en (spi_en), .clkdiv_reg (clkdiv_reg), .ss_sel (ss_sel), .irq (irq),
    .access_in (access_in), .packet_in (packet_in), .wait_out (wait_out),
    .access_out (access_out), .packet_out (packet_out), .wait_in (wait_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkpkt(input logic w, input logic [5:0] a,
                                          input logic [31:0] d, input logic [31:0] src);
    return {src, d, 26'd0, a, 5'h15, 2'b10, w};
  endfunction

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    access_in = 1'b1;
    packet_in = mkpkt(1'b1, a, d, 32'h0);
    @(negedge clk);
    access_in = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    logic [31:0] src;
    src = 32'hC0DE_0000 | {26'd0, a};
    @(negedge clk);
    access_in = 1'b1;
    packet_in = mkpkt(1'b0, a, 32'h0, src);
    @(negedge clk);
    access_in = 1'b0;
    chk("rd_valid", access_out, 1);
    chk("rd_dst", packet_out[39:8], src);
    chk("rd_ctrl", packet_out[7:0], 8'hAD);
    d = packet_out[71:40];
  endtask

  task automatic rx_push(input logic [63:0] d);
    @(negedge clk);
    rx_access = 1'b1;
    rx_data   = d;
    @(negedge clk);
    rx_access = 1'b0;
  endtask

  initial begin
    nreset = 1'b0; hw_en = 1'b1; rx_data = '0; rx_access = 1'b0; spi_state = 2'd0;
    fifo_prog_full = 1'b0; fifo_wait = 1'b0; access_in = 1'b0; packet_in = '0; wait_in = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // 1. reset state
    chk("rst_ss_sel", ss_sel, 4'b0001);
    chk("rst_irq", irq, 0);
    chk("rst_access_out", access_out, 0);
    chk("rst_wait_out", wait_out, 0);
    chk("rst_clkdiv_port", clkdiv_reg, 8'd1);
    bus_read(SPI_CLKDIV, rd); chk("rst_clkdiv", rd, 32'd1);
    bus_read(SPI_CONFIG, rd); chk("rst_config", rd, 32'd0);
    @(negedge clk);
    chk("rsp_drop", access_out, 0);

    // 2. configuration writes
    bus_write(SPI_CONFIG, 32'h1C);
    bus_write(SPI_CLKDIV, 32'h07);
    bus_write(SPI_SSEL, 32'h02);
    chk("cpol", cpol, 1);
    chk("cpha", cpha, 1);
    chk("lsbfirst", lsbfirst, 1);
    chk("spi_en", spi_en, 1);
    chk("clkdiv_port", clkdiv_reg, 8'd7);
    chk("ss_sel2", ss_sel, 4'b0100);
    bus_read(SPI_SSEL, rd); chk("ssel_rd", rd, 32'd2);
    bus_write(SPI_SSEL, 32'h09);
    chk("ss_sel_sat", ss_sel, 4'b1000);
    bus_write(SPI_CONFIG, 32'h1D);
    chk("spi_dis", spi_en, 0);
    bus_write(SPI_CONFIG, 32'h1C);
    bus_read(6'h3C, rd); chk("unmapped", rd, 32'hDEADBEEF);

    // 3. single word through the RX queue
    rx_push(64'h1111_2222_3333_4444);
    bus_read(SPI_STATUS, rd); chk("st_rxne", rd, 32'h01);
    bus_read(SPI_RX0, rd); chk("rx0", rd, 32'h3333_4444);
    bus_read(SPI_RX1, rd); chk("rx1", rd, 32'h1111_2222);
    bus_read(SPI_STATUS, rd); chk("st_empty", rd, 32'h00);
    bus_read(SPI_RX1, rd); chk("rx1_empty", rd, 32'h0);
    spi_state = 2'd2; fifo_prog_full = 1'b1;
    bus_read(SPI_STATUS, rd); chk("st_busy_pfull", rd, 32'h06);
    spi_state = 2'd0; fifo_prog_full = 1'b0;

    // 4. overflow, data retention, W1C
    for (int i = 0; i < 5; i++) rx_push({32'hA000_0000 + i, 32'hB000_0000 + i});
    bus_read(SPI_STATUS, rd); chk("st_ovf", rd, 32'h09);
    for (int i = 0; i < 4; i++) begin
      bus_read(SPI_RX0, rd); chk("ovf_lo", rd, 32'hB000_0000 + i);
      bus_read(SPI_RX1, rd); chk("ovf_hi", rd, 32'hA000_0000 + i);
    end
    bus_read(SPI_STATUS, rd); chk("st_ovf_empty", rd, 32'h08);
    bus_write(SPI_STATUS, 32'hF7);
    bus_read(SPI_STATUS, rd); chk("w1c_other", rd, 32'h08);
    bus_write(SPI_STATUS, 32'h08);
    bus_read(SPI_STATUS, rd); chk("w1c_ovf", rd, 32'h00);

    // same-cycle pop and push on a full queue
    for (int i = 0; i < 4; i++) rx_push({32'hA000_0000 + i, 32'h0});
    @(negedge clk);
    access_in = 1'b1; packet_in = mkpkt(1'b0, SPI_RX1, 32'h0, 32'h5);
    rx_access = 1'b1; rx_data = {32'hC5C5_C5C5, 32'h0};
    @(negedge clk);
    access_in = 1'b0; rx_access = 1'b0;
    chk("pp_valid", access_out, 1);
    chk("pp_data", packet_out[71:40], 32'hA000_0000);
    bus_read(SPI_STATUS, rd); chk("pp_no_ovf", rd, 32'h01);
    for (int i = 1; i < 4; i++) begin
      bus_read(SPI_RX1, rd); chk("pp_hi", rd, 32'hA000_0000 + i);
    end
    bus_read(SPI_RX1, rd); chk("pp_new", rd, 32'hC5C5_C5C5);

    // 5. response held by wait_in
    @(negedge clk);
    wait_in = 1'b1; access_in = 1'b1;
    packet_in = mkpkt(1'b0, SPI_CLKDIV, 32'h0, 32'h51);
    @(negedge clk);
    packet_in = mkpkt(1'b0, SPI_CONFIG, 32'h0, 32'h52);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", access_out, 1);
      chk("hold_data", packet_out[71:40], 32'd7);
      chk("hold_dst", packet_out[39:8], 32'h51);
      chk("hold_wait", wait_out, 1);
      if (i < 2) @(negedge clk);
    end
    wait_in = 1'b0;
    @(negedge clk);
    access_in = 1'b0;
    chk("next_valid", access_out, 1);
    chk("next_data", packet_out[71:40], 32'h1C);
    chk("next_dst", packet_out[39:8], 32'h52);
    @(negedge clk);
    chk("next_done", access_out, 0);

    // 6. interrupt
`ifdef SPI_MASTER_IRQ_EN
    irq_exp = 1'b1;
`else
    irq_exp = 1'b0;
`endif
    bus_write(SPI_CONFIG, 32'h02);
    bus_read(SPI_CONFIG, rd); chk("cfg_irqen", rd, {31'd0, irq_exp} << 1);
    rx_push(64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("irq_set", irq, irq_exp);
    bus_read(SPI_RX1, rd); chk("irq_pop", rd, 32'h0123_4567);
    @(negedge clk);
    chk("irq_clr", irq, 0);

    // reset in mid-operation
    bus_write(SPI_CLKDIV, 32'h33);
    rx_push(64'hDEAD_0000_BEEF_0000);
    @(negedge clk);
    wait_in = 1'b1; access_in = 1'b1;
    packet_in = mkpkt(1'b0, SPI_RX0, 32'h0, 32'h7);
    @(negedge clk);
    access_in = 1'b0;
    chk("mid_pending", access_out, 1);
    #2 nreset = 1'b0;
    #1 chk("mid_rst_access", access_out, 0);
    @(negedge clk);
    nreset = 1'b1; wait_in = 1'b0;
    bus_read(SPI_STATUS, rd); chk("mid_rst_status", rd, 32'h00);
    bus_read(SPI_CLKDIV, rd); chk("mid_rst_clkdiv", rd, 32'd1);
    chk("mid_rst_ss_sel", ss_sel, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
